// File: rtl/rtr_flow_ctrl_output.sv
// Credit-return transmitter: per-VC pending-credit counters drained one per cycle
// by a round-robin arbiter onto flow_ctrl_out. Optional checks: RTR_FLOW_CTRL_OUTPUT_CHECK_EN.
`ifndef FLOW_CTRL_TYPE_CREDIT
`define FLOW_CTRL_TYPE_CREDIT 0
`endif
`ifndef RESET_TYPE_ASYNC
`define RESET_TYPE_ASYNC 0
`endif

module rtr_flow_ctrl_output #(
    parameter int num_vcs        = 4,
    parameter int flow_ctrl_type = `FLOW_CTRL_TYPE_CREDIT,
    parameter int max_pending    = 8,
    parameter int reset_type     = `RESET_TYPE_ASYNC,
    localparam int vc_idx_width  = (num_vcs > 1) ? $clog2(num_vcs) : 0,
    localparam int pend_width    = $clog2(max_pending + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    active,
    input  logic                    fc_event_valid_in,
    input  logic [num_vcs-1:0]      fc_event_sel_in_ivc,
    output logic [vc_idx_width:0]   flow_ctrl_out,
    output logic                    fc_pending_out,
    output logic                    error
);

    localparam int IW = (vc_idx_width > 0) ? vc_idx_width : 1;
    localparam logic [pend_width-1:0] PMAX = pend_width'(max_pending);
    localparam logic [pend_width-1:0] PONE = pend_width'(1);

    generate
        if (flow_ctrl_type != `FLOW_CTRL_TYPE_CREDIT || reset_type != `RESET_TYPE_ASYNC) begin : g_bad_cfg
            $error("rtr_flow_ctrl_output: only credit flow control with async reset is supported");
        end
    endgenerate

    logic [num_vcs-1:0]                 inc, req, gnt, nz;
    logic [num_vcs-1:0][pend_width-1:0] pend_q, pend_d;
    logic [IW-1:0]                      ptr_q, ptr_d, gidx;
    logic [vc_idx_width:0]              fco_q, fco_d;
    logic                               en;

    assign inc = {num_vcs{fc_event_valid_in}} & fc_event_sel_in_ivc;

    for (genvar v = 0; v < num_vcs; v++) begin : g_vc
        assign nz[v]  = (pend_q[v] != '0);
        // Bypass: a fresh event requests even when its counter is empty.
        assign req[v] = nz[v] | inc[v];
    end

    assign fc_pending_out = |nz;
    assign en             = active | fc_pending_out | fco_q[0];
    assign flow_ctrl_out  = fco_q;

    // Round-robin: first requester at or after ptr_q wins.
    always_comb begin
        int v;
        v     = 0;
        gnt   = '0;
        gidx  = '0;
        ptr_d = ptr_q;
        for (int i = 0; i < num_vcs; i++) begin
            v = (int'(ptr_q) + i) % num_vcs;
            if (req[v] && gnt == '0) begin
                gnt[v] = 1'b1;
                gidx   = IW'(v);
                ptr_d  = IW'((v + 1) % num_vcs);
            end
        end
    end

    // Increment saturates at max_pending; inc and gnt together cancel.
    always_comb begin
        pend_d = pend_q;
        for (int v = 0; v < num_vcs; v++) begin
            if (inc[v] && !gnt[v]) begin
                if (pend_q[v] != PMAX) pend_d[v] = pend_q[v] + PONE;
            end else if (!inc[v] && gnt[v]) begin
                pend_d[v] = pend_q[v] - PONE;
            end
        end
    end

    // Index field is MSB-first starting at bit 1, zero when nothing is granted.
    always_comb begin
        fco_d    = '0;
        fco_d[0] = |gnt;
        for (int i = 0; i < vc_idx_width; i++) fco_d[i+1] = gidx[vc_idx_width-1-i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            ptr_q  <= '0;
            fco_q  <= '0;
        end else if (en) begin
            pend_q <= pend_d;
            ptr_q  <= ptr_d;
            fco_q  <= fco_d;
        end
    end

`ifdef RTR_FLOW_CTRL_OUTPUT_CHECK_EN
    logic [num_vcs-1:0] ovf;
    logic               err_q;

    always_comb begin
        ovf = '0;
        for (int v = 0; v < num_vcs; v++) ovf[v] = (pend_q[v] == PMAX) & inc[v] & ~gnt[v];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           err_q <= 1'b0;
        else if (en && |ovf) err_q <= 1'b1;
    end

    assign error = err_q;

    a_mask_without_valid: assert property (@(posedge clk) disable iff (reset)
        fc_event_valid_in || fc_event_sel_in_ivc == '0);

    for (genvar v = 0; v < num_vcs; v++) begin : g_chk
        a_pend_bound: assert property (@(posedge clk) disable iff (reset) pend_q[v] <= PMAX);
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_rtr_flow_ctrl_output.sv
// Directed bench for rtr_flow_ctrl_output (num_vcs=4, max_pending=8).
module tb_rtr_flow_ctrl_output;

    logic       clk = 1'b0;
    logic       reset;
    logic       active;
    logic       fc_event_valid_in;
    logic [3:0] fc_event_sel_in_ivc;
    logic [2:0] flow_ctrl_out;
    logic       fc_pending_out;
    logic       error;

    int errors = 0;
    int checks = 0;
    int cnt [4];
    int total;
    int seq [4];
    logic exp_err;

    rtr_flow_ctrl_output #(.num_vcs(4), .max_pending(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .active              (active),
        .fc_event_valid_in   (fc_event_valid_in),
        .fc_event_sel_in_ivc (fc_event_sel_in_ivc),
        .flow_ctrl_out       (flow_ctrl_out),
        .fc_pending_out      (fc_pending_out),
        .error               (error)
    );

    always #5 clk = ~clk;

    // Word layout: bit0 valid, bit1 index MSB, bit2 index LSB.
    localparam logic [2:0] W_VC0 = 3'b001;
    localparam logic [2:0] W_VC1 = 3'b101;
    localparam logic [2:0] W_VC2 = 3'b011;
    localparam logic [2:0] W_VC3 = 3'b111;

    function automatic int vc_of(input logic [2:0] w);
        case (w)
            W_VC0:   return 0;
            W_VC1:   return 1;
            W_VC2:   return 2;
            W_VC3:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [3:0] mask);
        fc_event_valid_in   = vld;
        fc_event_sel_in_ivc = mask;
    endtask

    task automatic clear_cnt();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        total = 0;
    endtask

    task automatic record();
        if (flow_ctrl_out[0]) begin
            total++;
            if (vc_of(flow_ctrl_out) >= 0) cnt[vc_of(flow_ctrl_out)]++;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            record();
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        drive(1'b0, 4'b0000);
        active = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
`ifdef RTR_FLOW_CTRL_OUTPUT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        reset  = 1'b1;
        active = 1'b1;
        drive(1'b0, 4'b0000);
        #3;
        chk("rst_fco", flow_ctrl_out, 0);
        chk("rst_pending", fc_pending_out, 0);
        chk("rst_error", error, 0);
        tick();
        reset = 1'b0;

        // Single credit on VC2 with one-cycle latency, no queuing.
        repeat (4) tick();
        drive(1'b1, 4'b0100);
        tick();
        chk("single_word", flow_ctrl_out, W_VC2);
        chk("single_pend", fc_pending_out, 0);
        drive(1'b0, 4'b0000);
        tick();
        chk("single_idle", flow_ctrl_out, 0);
        chk("single_pend2", fc_pending_out, 0);

        // Multi-hot 1011 from pointer 0: VC0, VC1, VC3 then idle.
        reset_dut();
        drive(1'b1, 4'b1011);
        tick();
        chk("mh_0", flow_ctrl_out, W_VC0);
        chk("mh_pend", fc_pending_out, 1);
        drive(1'b0, 4'b0000);
        tick();
        chk("mh_1", flow_ctrl_out, W_VC1);
        tick();
        chk("mh_2", flow_ctrl_out, W_VC3);
        chk("mh_pend_end", fc_pending_out, 0);
        tick();
        chk("mh_idle", flow_ctrl_out, 0);
        drive(1'b1, 4'b1111);
        tick();
        chk("mh_ptr_wrap", flow_ctrl_out, W_VC0);
        drive(1'b0, 4'b0000);
        drain(6);
        chk("mh_drained", fc_pending_out, 0);

        // Fairness: VC0+VC1 every cycle for 14 cycles, 14 credits each.
        reset_dut();
        clear_cnt();
        drive(1'b1, 4'b0011);
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i < 4) seq[i] = vc_of(flow_ctrl_out);
            record();
        end
        drive(1'b0, 4'b0000);
        drain(30);
        chk("fair_seq0", seq[0], 0);
        chk("fair_seq1", seq[1], 1);
        chk("fair_seq2", seq[2], 0);
        chk("fair_seq3", seq[3], 1);
        chk("fair_cnt0", cnt[0], 14);
        chk("fair_cnt1", cnt[1], 14);
        chk("fair_total", total, 28);
        chk("fair_error", error, 0);
        chk("fair_pend", fc_pending_out, 0);

        // Saturation: all VCs every cycle for 16 cycles; 4 grants each,
        // counters cap at 8, so 12 credits per VC reach the link.
        reset_dut();
        clear_cnt();
        drive(1'b1, 4'b1111);
        drain(16);
        drive(1'b0, 4'b0000);
        drain(40);
        chk("sat_cnt0", cnt[0], 12);
        chk("sat_cnt1", cnt[1], 12);
        chk("sat_cnt2", cnt[2], 12);
        chk("sat_cnt3", cnt[3], 12);
        chk("sat_error", error, exp_err);
        chk("sat_pend", fc_pending_out, 0);
        drain(3);
        chk("sat_error_sticky", error, exp_err);
        reset_dut();
        chk("sat_error_cleared", error, 0);

        // Reset in the middle of a drain discards queued credits.
        drive(1'b1, 4'b1111);
        repeat (3) tick();
        drive(1'b0, 4'b0000);
        tick();
        tick();
        chk("rd_busy", flow_ctrl_out[0], 1);
        chk("rd_busy_pend", fc_pending_out, 1);
        #2 reset = 1'b1;
        #1;
        chk("rd_fco_async", flow_ctrl_out, 0);
        chk("rd_pend_async", fc_pending_out, 0);
        tick();
        reset = 1'b0;
        clear_cnt();
        drain(10);
        chk("rd_no_more", total, 0);
        chk("rd_pend_after", fc_pending_out, 0);

        // Gating: queued credits still drain with active=0, then state freezes.
        reset_dut();
        drive(1'b1, 4'b1111);
        tick();
        chk("gate_first", flow_ctrl_out, W_VC0);
        active = 1'b0;
        drive(1'b0, 4'b0000);
        clear_cnt();
        drain(8);
        chk("gate_drained", total, 3);
        chk("gate_cnt3", cnt[3], 1);
        chk("gate_idle", flow_ctrl_out, 0);
        chk("gate_pend", fc_pending_out, 0);
        drive(1'b1, 4'b0001);
        tick();
        drive(1'b0, 4'b0000);
        tick();
        chk("gate_frozen_fco", flow_ctrl_out, 0);
        chk("gate_frozen_pend", fc_pending_out, 0);
        active = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
